// File: rtl/bbox_overlay.sv
// Bounding-box overlay: measures the extent of MATCH_COLOUR pixels in one frame and
// outlines that box in BOX_COLOUR on the following frame, with a fixed 1-cycle video latency.
module bbox_overlay #(
  parameter int                    DATA_WIDTH   = 24,
  parameter int                    COORD_W      = 11,
  parameter logic [DATA_WIDTH-1:0] MATCH_COLOUR = 24'hFFFFFF,
  parameter logic [DATA_WIDTH-1:0] BOX_COLOUR   = 24'hFF0000,
  parameter int                    MIN_HITS     = 64
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] i_vid_data,
  input  logic                  i_vid_hsync,
  input  logic                  i_vid_vsync,
  input  logic                  i_vid_VDE,
  output logic [DATA_WIDTH-1:0] o_vid_data,
  output logic                  o_vid_hsync,
  output logic                  o_vid_vsync,
  output logic                  o_vid_VDE,
  input  logic [3:0]            btn,
  input  logic [3:0]            sw,
  output logic [3:0]            led
);

  localparam int                 CNT_W      = 2 * COORD_W;
  localparam logic [COORD_W-1:0] C_MAX      = '1;
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]   MIN_HITS_C = CNT_W'(MIN_HITS);

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  vsync_q, vde_q;
  logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0]    xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [COORD_W-1:0]    dxmin_q, dxmin_d, dxmax_q, dxmax_d, dymin_q, dymin_d, dymax_q, dymax_d;
  logic                  valid_q, valid_d;
  logic                  tog_q, tog_d;
  logic                  frz_meta_q, frz_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  hsync_q, vsync_out_q, vde_out_q;

  logic vs_rise, vde_fall, hit, in_x, in_y, on_col, on_row, draw;
  logic unused_ok;

  assign unused_ok = ^{btn[3:1], sw[2:0]};

  assign vs_rise  = i_vid_vsync & ~vsync_q;
  assign vde_fall = vde_q & ~i_vid_VDE;
  // A hit coinciding with the frame-start edge belongs to neither frame, so it is dropped.
  assign hit      = i_vid_VDE && (i_vid_data == MATCH_COLOUR) && !vs_rise;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (i_vid_VDE) begin
      if (x_q != C_MAX) x_d = x_q + 1'b1;
    end else if (vde_fall) begin
      x_d = '0;
      if (y_q != C_MAX) y_d = y_q + 1'b1;
    end
    if (vs_rise) y_d = '0;
  end

  always_comb begin
    state_d = state_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    cnt_d   = cnt_q;
    dxmin_d = dxmin_q;
    dxmax_d = dxmax_q;
    dymin_d = dymin_q;
    dymax_d = dymax_q;
    valid_d = valid_q;
    tog_d   = tog_q;
    case (state_q)
      ST_WAIT: begin
        if (vs_rise) begin
          state_d = ST_ACCUM;
          xmin_d  = '1;
          ymin_d  = '1;
          xmax_d  = '0;
          ymax_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_ACCUM: begin
        if (vs_rise) begin
          state_d = ST_LATCH;
        end else if (hit) begin
          if (x_q < xmin_q) xmin_d = x_q;
          if (x_q > xmax_q) xmax_d = x_q;
          if (y_q < ymin_q) ymin_d = y_q;
          if (y_q > ymax_q) ymax_d = y_q;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LATCH: begin
        state_d = ST_ACCUM;
        tog_d   = ~tog_q;
        if (!frz_q) begin
          dxmin_d = xmin_q;
          dxmax_d = xmax_q;
          dymin_d = ymin_q;
          dymax_d = ymax_q;
          valid_d = (cnt_q >= MIN_HITS_C);
        end
        xmin_d = '1;
        ymin_d = '1;
        xmax_d = '0;
        ymax_d = '0;
        cnt_d  = '0;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Outline test is done on the incoming pixel so the overlay adds no extra latency.
  assign in_x   = (x_q >= dxmin_q) && (x_q <= dxmax_q);
  assign in_y   = (y_q >= dymin_q) && (y_q <= dymax_q);
  assign on_col = ((x_q == dxmin_q) || (x_q == dxmax_q)) && in_y;
  assign on_row = ((y_q == dymin_q) || (y_q == dymax_q)) && in_x;
  assign draw   = sw[3] && valid_q && i_vid_VDE && (on_col || on_row);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_WAIT;
      vsync_q     <= 1'b0;
      vde_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      xmin_q      <= '1;
      ymin_q      <= '1;
      xmax_q      <= '0;
      ymax_q      <= '0;
      cnt_q       <= '0;
      dxmin_q     <= '0;
      dxmax_q     <= '0;
      dymin_q     <= '0;
      dymax_q     <= '0;
      valid_q     <= 1'b0;
      tog_q       <= 1'b0;
      frz_meta_q  <= 1'b0;
      frz_q       <= 1'b0;
      data_q      <= '0;
      hsync_q     <= 1'b0;
      vsync_out_q <= 1'b0;
      vde_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= i_vid_vsync;
      vde_q       <= i_vid_VDE;
      x_q         <= x_d;
      y_q         <= y_d;
      xmin_q      <= xmin_d;
      ymin_q      <= ymin_d;
      xmax_q      <= xmax_d;
      ymax_q      <= ymax_d;
      cnt_q       <= cnt_d;
      dxmin_q     <= dxmin_d;
      dxmax_q     <= dxmax_d;
      dymin_q     <= dymin_d;
      dymax_q     <= dymax_d;
      valid_q     <= valid_d;
      tog_q       <= tog_d;
      frz_meta_q  <= btn[0];
      frz_q       <= frz_meta_q;
      data_q      <= draw ? BOX_COLOUR : i_vid_data;
      hsync_q     <= i_vid_hsync;
      vsync_out_q <= i_vid_vsync;
      vde_out_q   <= i_vid_VDE;
    end
  end

  assign o_vid_data  = data_q;
  assign o_vid_hsync = hsync_q;
  assign o_vid_vsync = vsync_out_q;
  assign o_vid_VDE   = vde_out_q;
  assign led         = {cnt_q == CNT_MAX, tog_q, frz_q, valid_q};

endmodule
